parking_lot_ctrl: RTL

//  Next-generation parking occupancy controller: two car classes (uni, guest), parametrised

---
 rtl/parking_pkg.sv | 24 ++
 rtl/parking_lot_ctrl_if.sv | 23 ++
 rtl/parking_gate_fsm.sv | 61 ++++++
 rtl/parking_lot_ctrl.sv | 76 +++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and helpers for the parking lot controller: gate FSM states,
// default hour boundaries and the time-of-day guest capacity rule.
package parking_pkg;

  typedef enum logic [1:0] {IDLE, OPEN, DENY} gate_state_e;

  localparam int DEF_DAY_START  = 8;
  localparam int DEF_RAMP_START = 13;
  localparam int DEF_RAMP_END   = 16;

  // Hours outside the day window (including nonsense hours > 23) get the full guest cap.
  function automatic int guest_cap(input logic [4:0] hour, input int gmin, input int gmax,
                                   input int day_start, input int ramp_start,
                                   input int ramp_end, input int step);
    int h;
    int cap;
    h = int'(hour);
    if (h >= day_start && h < ramp_start)     cap = gmin;
    else if (h >= ramp_start && h < ramp_end) cap = gmin + (h - ramp_start) * step;
    else                                      cap = gmax;
    return cap;
  endfunction

endpackage

// File: rtl/parking_lot_ctrl_if.sv
// Entry/exit handshake and display bus between the lot sensors and the controller.
interface parking_lot_ctrl_if #(parameter int CNT_W = 10);
  logic [4:0]       hour;
  logic             entry_valid, entry_is_uni, entry_ready;
  logic             exit_valid, exit_is_uni;
  logic [CNT_W-1:0] uni_parked_car, parked_car, uni_vacated_space, vacated_space;
  logic             uni_is_vacated_space, is_vacated_space;
  logic             gate_open, entry_granted, entry_denied, exit_underflow;

  modport master (
    output hour, entry_valid, entry_is_uni, exit_valid, exit_is_uni,
    input  entry_ready, uni_parked_car, parked_car, uni_vacated_space, vacated_space,
           uni_is_vacated_space, is_vacated_space, gate_open, entry_granted,
           entry_denied, exit_underflow
  );

  modport slave (
    input  hour, entry_valid, entry_is_uni, exit_valid, exit_is_uni,
    output entry_ready, uni_parked_car, parked_car, uni_vacated_space, vacated_space,
           uni_is_vacated_space, is_vacated_space, gate_open, entry_granted,
           entry_denied, exit_underflow
  );
endinterface

// File: rtl/parking_gate_fsm.sv
// Entry gate FSM: accepts one request when idle, then holds the barrier open
// for GATE_HOLD cycles on a grant or spends one cycle in DENY on a refusal.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int GATE_HOLD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_valid,
  input  logic has_space,
  output logic entry_ready,
  output logic accept,
  output logic gate_open,
  output logic entry_granted,
  output logic entry_denied
);
  localparam int HOLD_W = (GATE_HOLD > 1) ? $clog2(GATE_HOLD) : 1;

  gate_state_e       state;
  logic [HOLD_W-1:0] hold_cnt;

  assign entry_ready = (state == IDLE);
  assign accept      = entry_ready && entry_valid && has_space;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      hold_cnt      <= '0;
      gate_open     <= 1'b0;
      entry_granted <= 1'b0;
      entry_denied  <= 1'b0;
    end else begin
      entry_granted <= 1'b0;
      entry_denied  <= 1'b0;
      case (state)
        IDLE: if (entry_valid) begin
          if (has_space) begin
            state         <= OPEN;
            gate_open     <= 1'b1;
            hold_cnt      <= HOLD_W'(GATE_HOLD - 1);
            entry_granted <= 1'b1;
          end else begin
            state        <= DENY;
            entry_denied <= 1'b1;
          end
        end
        // hold_cnt counts the open cycles still to go after the current one
        OPEN: if (hold_cnt == '0) begin
          state     <= IDLE;
          gate_open <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - 1'b1;
        end
        DENY:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/parking_lot_ctrl.sv
// Parking occupancy controller: per-class counters, free-space arithmetic with
// saturation, exit handling, and the entry gate FSM.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int CNT_W      = 10,
  parameter int TOTAL_CAP  = 700,
  parameter int UNI_CAP    = 500,
  parameter int GUEST_MIN  = 200,
  parameter int GUEST_MAX  = 500,
  parameter int DAY_START  = DEF_DAY_START,
  parameter int RAMP_START = DEF_RAMP_START,
  parameter int RAMP_END   = DEF_RAMP_END,
  parameter int RAMP_STEP  = 50,
  parameter int GATE_HOLD  = 4
) (
  input logic               clk,
  input logic               reset,
  parking_lot_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] TOTAL = CNT_W'(TOTAL_CAP);
  localparam logic [CNT_W-1:0] UNI   = CNT_W'(UNI_CAP);

  logic [CNT_W-1:0] uni_cnt, guest_cnt, gcap, total_free, uni_vac, guest_vac;
  logic             uni_ok, guest_ok, accept;
  logic             inc_uni, inc_guest, dec_uni, dec_guest;

  assign gcap       = CNT_W'(guest_cap(bus.hour, GUEST_MIN, GUEST_MAX, DAY_START,
                                       RAMP_START, RAMP_END, RAMP_STEP));
  assign total_free = TOTAL - uni_cnt - guest_cnt;

  // Caps can fall below occupancy when the hour changes, so clamp instead of wrapping.
  assign uni_vac   = (uni_cnt   >= UNI)  ? '0 : UNI  - uni_cnt;
  assign guest_vac = (guest_cnt >= gcap) ? '0 : gcap - guest_cnt;
  assign uni_ok    = (uni_vac   != '0) && (total_free != '0);
  assign guest_ok  = (guest_vac != '0) && (total_free != '0);

  parking_gate_fsm #(.GATE_HOLD(GATE_HOLD)) u_gate (
    .clk           (clk),
    .reset         (reset),
    .entry_valid   (bus.entry_valid),
    .has_space     (bus.entry_is_uni ? uni_ok : guest_ok),
    .entry_ready   (bus.entry_ready),
    .accept        (accept),
    .gate_open     (bus.gate_open),
    .entry_granted (bus.entry_granted),
    .entry_denied  (bus.entry_denied)
  );

  assign inc_uni   = accept &&  bus.entry_is_uni;
  assign inc_guest = accept && !bus.entry_is_uni;
  assign dec_uni   = bus.exit_valid &&  bus.exit_is_uni && (uni_cnt   != '0);
  assign dec_guest = bus.exit_valid && !bus.exit_is_uni && (guest_cnt != '0);

  // Entry and exit of the same class on one edge cancel out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uni_cnt            <= '0;
      guest_cnt          <= '0;
      bus.exit_underflow <= 1'b0;
    end else begin
      uni_cnt            <= uni_cnt   + CNT_W'(inc_uni)   - CNT_W'(dec_uni);
      guest_cnt          <= guest_cnt + CNT_W'(inc_guest) - CNT_W'(dec_guest);
      bus.exit_underflow <= bus.exit_valid &&
                            (bus.exit_is_uni ? (uni_cnt == '0) : (guest_cnt == '0));
    end
  end

  assign bus.uni_parked_car       = uni_cnt;
  assign bus.parked_car           = guest_cnt;
  assign bus.uni_vacated_space    = uni_vac;
  assign bus.vacated_space        = guest_vac;
  assign bus.uni_is_vacated_space = uni_ok;
  assign bus.is_vacated_space     = guest_ok;

endmodule
